// File: rtl/axis_insert_header_sched_if.sv
// Bundle of header-request, header-insert, payload-gate and output-monitor signals
// shared by the header insertion scheduler and its surroundings.
interface axis_insert_header_sched_if #(
  parameter int DATA_WD      = 32,
  parameter int DATA_BYTE_WD = DATA_WD / 8,
  parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD),
  parameter int NUM_SRC      = 4,
  parameter int SRC_WD       = $clog2(NUM_SRC)
);

  // header requesters
  logic [NUM_SRC-1:0]              src_valid_insert;
  logic [NUM_SRC*DATA_WD-1:0]      src_data_insert;
  logic [NUM_SRC*DATA_BYTE_WD-1:0] src_keep_insert;
  logic [NUM_SRC*BYTE_CNT_WD-1:0]  src_byte_insert_cnt;
  logic [NUM_SRC-1:0]              src_ready_insert;

  // selected header towards the insertion datapath
  logic                    valid_insert;
  logic [DATA_WD-1:0]      data_insert;
  logic [DATA_BYTE_WD-1:0] keep_insert;
  logic [BYTE_CNT_WD-1:0]  byte_insert_cnt;
  logic                    ready_insert;

  // payload gate
  logic s_valid_in;
  logic s_last_in;
  logic s_ready_in;
  logic m_valid_in;
  logic m_ready_in;

  // datapath output monitor
  logic mon_valid_out;
  logic mon_ready_out;
  logic mon_last_out;

  // status
  logic [SRC_WD-1:0] grant_id;
  logic              busy;
  logic [15:0]       pkt_cnt;
  logic              err;

  // scheduler side
  modport master (
    input  src_valid_insert, src_data_insert, src_keep_insert, src_byte_insert_cnt,
    output src_ready_insert,
    output valid_insert, data_insert, keep_insert, byte_insert_cnt,
    input  ready_insert,
    input  s_valid_in, s_last_in, m_ready_in,
    output s_ready_in, m_valid_in,
    input  mon_valid_out, mon_ready_out, mon_last_out,
    output grant_id, busy, pkt_cnt, err
  );

  // environment side
  modport slave (
    output src_valid_insert, src_data_insert, src_keep_insert, src_byte_insert_cnt,
    input  src_ready_insert,
    input  valid_insert, data_insert, keep_insert, byte_insert_cnt,
    output ready_insert,
    output s_valid_in, s_last_in, m_ready_in,
    input  s_ready_in, m_valid_in,
    output mon_valid_out, mon_ready_out, mon_last_out,
    input  grant_id, busy, pkt_cnt, err
  );

endinterface

// File: rtl/axis_insert_header_sched.sv
// Round-robin scheduler granting one header per packet to a shared insertion datapath,
// gating the payload and holding the grant until the packet leaves the datapath.
module axis_insert_header_sched #(
  parameter int DATA_WD      = 32,
  parameter int DATA_BYTE_WD = DATA_WD / 8,
  parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD),
  parameter int NUM_SRC      = 4,
  parameter int SRC_WD       = $clog2(NUM_SRC)
) (
  input  logic                       clk,
  input  logic                       rst,
  axis_insert_header_sched_if.master bus
);

  localparam int unsigned NSRC = NUM_SRC;

  typedef enum logic [1:0] {
    IDLE,
    HDR,
    PLD,
    DRAIN
  } state_t;

  state_t            state;
  logic [SRC_WD-1:0] grant_q;
  logic [SRC_WD-1:0] last_grant;
  logic [15:0]       pkt_cnt_q;
  logic              err_q;
  logic              busy_q;

  logic [SRC_WD-1:0] winner;
  logic              any_req;
  int unsigned       cand;

  logic hdr_fire;
  logic in_last_fire;
  logic out_last_fire;

  // Lowest offset from last_grant+1 wins; the flag keeps later hits from overriding.
  always_comb begin
    winner  = last_grant;
    any_req = 1'b0;
    cand    = 0;
    for (int unsigned off = 1; off <= NSRC; off++) begin
      cand = (32'(last_grant) + off) % NSRC;
      if (!any_req && bus.src_valid_insert[SRC_WD'(cand)]) begin
        any_req = 1'b1;
        winner  = SRC_WD'(cand);
      end
    end
  end

  always_comb begin
    hdr_fire      = (state == HDR) && bus.src_valid_insert[grant_q] && bus.ready_insert;
    in_last_fire  = (state == PLD) && bus.s_valid_in && bus.m_ready_in && bus.s_last_in;
    out_last_fire = bus.mon_valid_out && bus.mon_ready_out && bus.mon_last_out;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      grant_q    <= '0;
      last_grant <= SRC_WD'(NUM_SRC - 1);
      pkt_cnt_q  <= '0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (out_last_fire) begin
            err_q <= 1'b1;
          end
          if (any_req) begin
            grant_q <= winner;
            state   <= HDR;
            busy_q  <= 1'b1;
          end
        end
        HDR: begin
          if (out_last_fire) begin
            err_q <= 1'b1;
          end
          if (hdr_fire) begin
            state <= PLD;
          end
        end
        PLD: begin
          // Output last in PLD is only legal when it coincides with the input last.
          if (out_last_fire) begin
            if (in_last_fire) begin
              pkt_cnt_q  <= pkt_cnt_q + 16'd1;
              last_grant <= grant_q;
              state      <= IDLE;
              busy_q     <= 1'b0;
            end else begin
              err_q <= 1'b1;
            end
          end else if (in_last_fire) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (out_last_fire) begin
            pkt_cnt_q  <= pkt_cnt_q + 16'd1;
            last_grant <= grant_q;
            state      <= IDLE;
            busy_q     <= 1'b0;
          end
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  // Handshake outputs are held off during the reset cycle so nothing is accepted there.
  always_comb begin
    bus.valid_insert     = 1'b0;
    bus.src_ready_insert = '0;
    bus.data_insert      = '0;
    bus.keep_insert      = '0;
    bus.byte_insert_cnt  = '0;
    bus.m_valid_in       = 1'b0;
    bus.s_ready_in       = 1'b0;
    if (!rst) begin
      if (state == HDR) begin
        bus.valid_insert              = bus.src_valid_insert[grant_q];
        bus.src_ready_insert[grant_q] = bus.ready_insert;
        bus.data_insert     = bus.src_data_insert[32'(grant_q) * DATA_WD +: DATA_WD];
        bus.keep_insert     = bus.src_keep_insert[32'(grant_q) * DATA_BYTE_WD +: DATA_BYTE_WD];
        bus.byte_insert_cnt = bus.src_byte_insert_cnt[32'(grant_q) * BYTE_CNT_WD +: BYTE_CNT_WD];
      end
      if (state == PLD) begin
        bus.m_valid_in = bus.s_valid_in;
        bus.s_ready_in = bus.m_ready_in;
      end
    end
  end

  assign bus.grant_id = grant_q;
  assign bus.busy     = busy_q;
  assign bus.pkt_cnt  = pkt_cnt_q;
  assign bus.err      = err_q;

endmodule

// File: tb/tb_axis_insert_header_sched.sv
// Randomised directed bench for axis_insert_header_sched against a packet-level reference model.
module tb_axis_insert_header_sched;

  localparam int DW = 32;
  localparam int BW = 4;
  localparam int CW = 2;
  localparam int NS = 4;
  localparam int SW = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  axis_insert_header_sched_if #(
    .DATA_WD(DW), .DATA_BYTE_WD(BW), .BYTE_CNT_WD(CW), .NUM_SRC(NS), .SRC_WD(SW)
  ) bus ();

  axis_insert_header_sched #(
    .DATA_WD(DW), .DATA_BYTE_WD(BW), .BYTE_CNT_WD(CW), .NUM_SRC(NS), .SRC_WD(SW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // packet-level reference model
  int        m_last;
  int        m_cnt;
  logic      m_err;
  logic [DW-1:0] hd [NS];
  logic [BW-1:0] kp [NS];
  logic [CW-1:0] cn [NS];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic int rr_pick(input logic [NS-1:0] req, input int last);
    for (int k = 1; k <= NS; k++) begin
      if (req[(last + k) % NS]) return (last + k) % NS;
    end
    return 0;
  endfunction

  task automatic idle_inputs();
    bus.src_valid_insert    = '0;
    bus.src_data_insert     = '0;
    bus.src_keep_insert     = '0;
    bus.src_byte_insert_cnt = '0;
    bus.ready_insert        = 1'b0;
    bus.s_valid_in          = 1'b0;
    bus.s_last_in           = 1'b0;
    bus.m_ready_in          = 1'b0;
    bus.mon_valid_out       = 1'b0;
    bus.mon_ready_out       = 1'b0;
    bus.mon_last_out        = 1'b0;
  endtask

  task automatic set_mon(input logic v);
    bus.mon_valid_out = v;
    bus.mon_ready_out = v;
    bus.mon_last_out  = v;
  endtask

  // mode: 0 normal, 1 output last in HDR, 2 input+output last together, 3 output last early in PLD
  // Entry and exit: posedge+1 of a cycle in which the DUT is IDLE.
  task automatic pkt(input logic [NS-1:0] req, input int stall, input bit drop,
                     input int mode, input int beats, input bit fixed);
    int g;
    int acc;
    int budget;
    bit drop_now;
    for (int i = 0; i < NS; i++) begin
      hd[i] = $urandom;
      kp[i] = BW'($urandom);
      cn[i] = CW'($urandom);
    end
    if (fixed) begin
      hd[2] = 32'hA1B2C3D4;
      kp[2] = 4'b1111;
    end
    for (int i = 0; i < NS; i++) begin
      bus.src_data_insert[i*DW +: DW]     = hd[i];
      bus.src_keep_insert[i*BW +: BW]     = kp[i];
      bus.src_byte_insert_cnt[i*CW +: CW] = cn[i];
    end
    g = rr_pick(req, m_last);
    bus.src_valid_insert = req;
    bus.s_valid_in = 1'b1;
    bus.m_ready_in = 1'b1;
    bus.s_last_in  = 1'b0;
    @(negedge clk);
    chk("idle_valid_insert", bus.valid_insert, 0);
    chk("idle_gate", {bus.s_ready_in, bus.m_valid_in}, 0);

    cyc();
    @(negedge clk);
    chk("hdr_grant", bus.grant_id, g);
    chk("hdr_valid", bus.valid_insert, 1);
    chk("hdr_data", bus.data_insert, hd[g]);
    chk("hdr_keep", bus.keep_insert, kp[g]);
    chk("hdr_cnt", bus.byte_insert_cnt, cn[g]);
    chk("hdr_busy", bus.busy, 1);
    chk("hdr_gate", {bus.s_ready_in, bus.m_valid_in}, 0);
    chk("hdr_src_ready", bus.src_ready_insert, 0);

    for (int s = 0; s < stall; s++) begin
      cyc();
      drop_now = drop && (s < 2);
      bus.src_valid_insert = req;
      if (drop_now) bus.src_valid_insert[g] = 1'b0;
      bus.ready_insert = drop_now;
      set_mon(mode == 1 && s == 0);
      if (mode == 1 && s == 0) m_err = 1'b1;
      @(negedge clk);
      chk("stall_grant", bus.grant_id, g);
      chk("stall_valid", bus.valid_insert, !drop_now);
      chk("stall_src_ready", bus.src_ready_insert, drop_now ? 64'(1 << g) : 64'd0);
      chk("stall_gate", {bus.s_ready_in, bus.m_valid_in}, 0);
      if (mode == 1 && s == 1) chk("hdr_err_set", bus.err, 1);
    end

    cyc();
    bus.src_valid_insert = req;
    bus.ready_insert = 1'b1;
    set_mon(1'b0);
    @(negedge clk);
    chk("accept_src_ready", bus.src_ready_insert, 64'(1 << g));
    chk("accept_valid", bus.valid_insert, 1);
    chk("accept_gate", {bus.s_ready_in, bus.m_valid_in}, 0);
    cyc();
    bus.ready_insert = 1'b0;

    acc = 0;
    budget = 0;
    while (acc < beats && budget < 200) begin
      bus.s_valid_in = 1'($urandom_range(0, 1));
      bus.m_ready_in = 1'($urandom_range(0, 1));
      bus.s_last_in  = (acc == beats - 1);
      set_mon(1'b0);
      bus.ready_insert = 1'($urandom_range(0, 1));
      if (mode == 2 && acc == beats - 1) begin
        bus.s_valid_in = 1'b1;
        bus.m_ready_in = 1'b1;
        set_mon(1'b1);
      end
      if (mode == 3 && budget == 0) begin
        bus.s_valid_in = 1'b0;
        set_mon(1'b1);
        m_err = 1'b1;
      end
      @(negedge clk);
      chk("pld_m_valid", bus.m_valid_in, bus.s_valid_in);
      chk("pld_s_ready", bus.s_ready_in, bus.m_ready_in);
      chk("pld_no_hdr", {bus.valid_insert, bus.src_ready_insert}, 0);
      if (bus.s_valid_in && bus.m_ready_in) acc++;
      budget++;
      cyc();
    end
    chk("pld_beats", acc, beats);
    set_mon(1'b0);
    bus.ready_insert = 1'b0;
    bus.s_last_in  = 1'b0;
    bus.s_valid_in = 1'b1;
    bus.m_ready_in = 1'b1;

    if (mode != 2) begin
      for (int d = 0; d < int'($urandom_range(1, 3)); d++) begin
        bus.mon_valid_out = 1'($urandom_range(0, 1));
        bus.mon_ready_out = 1'b1;
        bus.mon_last_out  = 1'b0;
        @(negedge clk);
        chk("drain_gate", {bus.s_ready_in, bus.m_valid_in}, 0);
        chk("drain_busy", bus.busy, 1);
        cyc();
      end
      set_mon(1'b1);
      @(negedge clk);
      chk("drain_last_busy", bus.busy, 1);
      cyc();
      set_mon(1'b0);
    end
    m_cnt  = (m_cnt + 1) % 65536;
    m_last = g;

    @(negedge clk);
    chk("done_busy", bus.busy, 0);
    chk("done_pkt_cnt", bus.pkt_cnt, m_cnt);
    chk("done_grant", bus.grant_id, g);
    chk("done_err", bus.err, m_err);
    chk("done_outputs", {bus.valid_insert, bus.s_ready_in, bus.m_valid_in}, 0);
    bus.src_valid_insert = '0;
    bus.s_valid_in = 1'b0;
    cyc();
  endtask

  initial begin
    int st;
    logic [NS-1:0] rq;
    idle_inputs();
    rst = 1'b1;
    cyc();
    cyc();
    @(negedge clk);
    chk("rst_grant", bus.grant_id, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_pkt_cnt", bus.pkt_cnt, 0);
    chk("rst_err", bus.err, 0);
    chk("rst_handshakes", {bus.valid_insert, bus.src_ready_insert, bus.s_ready_in, bus.m_valid_in}, 0);
    rst = 1'b0;
    m_last = NS - 1;
    m_cnt  = 0;
    m_err  = 1'b0;
    cyc();

    pkt(4'b0100, 5, 1'b1, 0, 3, 1'b1);

    for (int p = 0; p < 8; p++) begin
      pkt(4'b1111, 0, 1'b0, 0, int'($urandom_range(1, 4)), 1'b0);
    end

    pkt(4'b1111, 3, 1'b0, 1, 2, 1'b0);
    pkt(4'b1011, 1, 1'b0, 2, 3, 1'b0);

    for (int p = 0; p < 6; p++) begin
      rq = NS'($urandom_range(1, 15));
      st = int'($urandom_range(0, 3));
      pkt(rq, st, (st >= 2) ? 1'($urandom_range(0, 1)) : 1'b0,
          int'($urandom_range(0, 1)) * 2, int'($urandom_range(1, 4)), 1'b0);
    end

    // reset while the packet is draining
    bus.src_valid_insert = 4'b1111;
    cyc();
    bus.ready_insert = 1'b1;
    cyc();
    bus.ready_insert = 1'b0;
    bus.s_valid_in = 1'b1;
    bus.m_ready_in = 1'b1;
    bus.s_last_in  = 1'b1;
    cyc();
    bus.s_valid_in = 1'b0;
    bus.s_last_in  = 1'b0;
    bus.src_valid_insert = '0;
    @(negedge clk);
    chk("pre_rst_busy", bus.busy, 1);
    cyc();
    rst = 1'b1;
    bus.ready_insert = 1'b1;
    bus.s_valid_in = 1'b1;
    cyc();
    rst = 1'b0;
    bus.ready_insert = 1'b0;
    bus.s_valid_in = 1'b0;
    m_last = NS - 1;
    m_cnt  = 0;
    m_err  = 1'b0;
    @(negedge clk);
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_pkt_cnt", bus.pkt_cnt, 0);
    chk("mid_rst_err", bus.err, 0);
    chk("mid_rst_grant", bus.grant_id, 0);
    chk("mid_rst_handshakes", {bus.valid_insert, bus.src_ready_insert, bus.s_ready_in, bus.m_valid_in}, 0);
    cyc();

    pkt(4'b1111, 0, 1'b0, 0, 2, 1'b0);
    pkt(4'b0110, 1, 1'b0, 3, 3, 1'b0);
    pkt(NS'($urandom_range(1, 15)), 2, 1'b1, 0, 2, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/axis_insert_header_sched.md
# axis_insert_header_sched

Scheduler that shares one AXI-Stream header-insertion datapath among NUM_SRC header requesters. Each packet gets exactly one header: the block arbitrates round-robin, presents the winning header to the insertion datapath, and opens the payload path. It then holds the grant until the packet's last beat has left the datapath output. It sits between the header sources, the payload source and the header-insertion block.

## Interface
- DATA_WD, 32, payload/header data width
- DATA_BYTE_WD, DATA_WD/8, keep width
- BYTE_CNT_WD, $clog2(DATA_BYTE_WD), header byte-count width
- NUM_SRC, 4, number of header requesters (2..16)
- SRC_WD, $clog2(NUM_SRC), grant index width

- clk  in  1  single clock
- rst  in  1  synchronous, active-high reset
- src_valid_insert  in  NUM_SRC  per-source header valid
- src_data_insert  in  NUM_SRC*DATA_WD  headers, source i at [i*DATA_WD +: DATA_WD]
- src_keep_insert  in  NUM_SRC*DATA_BYTE_WD  header keeps, packed the same way
- src_byte_insert_cnt  in  NUM_SRC*BYTE_CNT_WD  header byte counts, packed the same way
- src_ready_insert  out  NUM_SRC  per-source header accept
- valid_insert  out  1  header valid to insertion datapath
- data_insert  out  DATA_WD  selected header data
- keep_insert  out  DATA_BYTE_WD  selected header keep
- byte_insert_cnt  out  BYTE_CNT_WD  selected byte count
- ready_insert  in  1  insertion datapath header ready
- s_valid_in  in  1  payload valid from upstream
- s_last_in  in  1  payload last from upstream
- s_ready_in  out  1  payload ready to upstream
- m_valid_in  out  1  gated payload valid to datapath
- m_ready_in  in  1  payload ready from datapath
- mon_valid_out, mon_ready_out, mon_last_out  in  1 each  datapath output handshake monitor
- grant_id  out  SRC_WD  currently or last granted source
- busy  out  1  high in any state except IDLE
- pkt_cnt  out  16  completed packets, wraps 0xFFFF→0
- err  out  1  sticky protocol error

## Operation
- FSM states: IDLE, HDR, PLD, DRAIN.
- IDLE:
  - If any src_valid_insert is set, pick the winner round-robin. Priority starts at last_grant+1 and wraps modulo NUM_SRC.
  - Register the winner in grant_id and go to HDR.
- HDR:
  - valid_insert = src_valid_insert[grant_id]. data/keep/byte_cnt are muxed combinationally from the granted source.
  - src_ready_insert[grant_id] = ready_insert. All other src_ready_insert bits are 0.
  - On valid_insert & ready_insert, go to PLD.
  - If the granted source drops its valid, stay in HDR (no re-arbitration).
- PLD:
  - pass_en=1, so m_valid_in = s_valid_in and s_ready_in = m_ready_in.
  - On s_valid_in & s_ready_in & s_last_in, go to DRAIN.
- DRAIN:
  - pass_en=0.
  - On mon_valid_out & mon_ready_out & mon_last_out: pkt_cnt+1, last_grant ← grant_id, go to IDLE.
- Outside PLD: m_valid_in=0 and s_ready_in=0.
- Outside HDR: valid_insert=0, all src_ready_insert=0, and data/keep/byte_cnt outputs are 0.
- Simultaneous events in PLD:
  - Input last and output last in the same cycle: count the packet and go directly to IDLE.
  - Output last in PLD without input last: set err, stay in PLD.
- Output last in IDLE or HDR: set err, ignore it.
- err clears only on rst.

## Timing
- Reset values (synchronous, on the clk edge with rst=1):
  - state=IDLE, grant_id=0, last_grant=NUM_SRC-1 (source 0 has first priority), pkt_cnt=0, err=0.
  - All handshake outputs are 0.
- rst mid-packet: all outputs return to reset values on the next edge. No partial header or payload beat is accepted in the reset cycle.
- Latency from request to header valid: a request seen in IDLE at cycle N gives valid_insert=1 at cycle N+1.
- Header acceptance at cycle M gives m_valid_in/s_ready_in enabled from cycle M+1.
- Input last accepted at cycle K closes the payload gate from K+1.
- Output last at cycle L puts the FSM in IDLE at L+1. Re-arbitration happens at L+1, so the next valid_insert appears at L+2 at the earliest.
- Grant is stable from the HDR entry until the IDLE return. Arbitration pointer updates only on packet completion.

## Test plan
- Single source 2 requests; header 0xA1B2C3D4, keep 4'b1111; 3-beat payload → valid_insert at cycle 1, payload gate opens only after header accepted, pkt_cnt=1, grant_id=2.
- All 4 sources request continuously for 8 packets → grant order 0,1,2,3,0,1,2,3 and pkt_cnt=8.
- ready_insert held low 5 cycles in HDR; granted source drops valid for 2 cycles → stays in HDR, no other grant, header accepted once.
- Payload arrives before header is accepted → s_ready_in=0 and m_valid_in=0 until cycle after acceptance; no beat lost.
- mon_last_out pulsed in HDR → err=1 and stays 1; FSM continues normally.
- rst asserted in DRAIN → next cycle state IDLE, all outputs 0, err=0, pkt_cnt=0; new request then granted to source 0.
